// File: rtl/dense_instr_decoder_if.sv
// Stream-in / command-out bundle of the dense instruction decoder.
// slave = decoder side, master = instruction source and command consumer.
`timescale 1ns/1ps
interface dense_instr_decoder_if #(
  parameter int size            = 3,
  parameter int data_size       = 16,
  parameter int cost_type_size  = 8,
  parameter int dense_type_size = 4,
  parameter int act_type_size   = 4
);
  logic [31:0]                   in_word;
  logic                          in_valid;
  logic                          in_ready;
  logic [act_type_size-1:0]      act_type;
  logic [dense_type_size-1:0]    dense_type;
  logic [cost_type_size-1:0]     cost_type;
  logic [data_size*size-1:0]     w;
  logic [data_size*size-1:0]     x;
  logic [data_size*size-1:0]     label;
  logic [31:0]                   w_layer_index;
  logic [31:0]                   w_row_index;
  logic                          is_update;
  logic                          load_w;
  logic                          backprop_cost;
  logic                          out_valid;
  logic                          out_ready;
  logic                          illegal_op;
  logic [15:0]                   err_count;

  modport slave (
    input  in_word, in_valid, out_ready,
    output in_ready, act_type, dense_type, cost_type, w, x, label,
           w_layer_index, w_row_index, is_update, load_w, backprop_cost,
           out_valid, illegal_op, err_count
  );

  modport master (
    output in_word, in_valid, out_ready,
    input  in_ready, act_type, dense_type, cost_type, w, x, label,
           w_layer_index, w_row_index, is_update, load_w, backprop_cost,
           out_valid, illegal_op, err_count
  );
endinterface

// File: rtl/dense_instr_decoder.sv
// Parses header + payload words into one held dense command for the decode register.
// Optional DECODE_ERR_COUNT_EN builds a saturating illegal-opcode counter.
`timescale 1ns/1ps
module dense_instr_decoder #(
  parameter int size            = 3,
  parameter int data_size       = 16,
  parameter int cost_type_size  = 8,
  parameter int dense_type_size = 4,
  parameter int act_type_size   = 4
) (
  input logic                 clk,
  input logic                 rst,
  dense_instr_decoder_if.slave bus
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] IDX_L  = 3'd1;
  localparam logic [2:0] IDX_R  = 3'd2;
  localparam logic [2:0] LD_W   = 3'd3;
  localparam logic [2:0] LD_X   = 3'd4;
  localparam logic [2:0] LD_LBL = 3'd5;
  localparam logic [2:0] EMIT   = 3'd6;

  localparam logic [3:0] OP_LOAD_W   = 4'd1;
  localparam logic [3:0] OP_FORWARD  = 4'd2;
  localparam logic [3:0] OP_TRAIN    = 4'd3;
  localparam logic [3:0] OP_BACKPROP = 4'd4;

  localparam int cnt_w = (size > 1) ? $clog2(size) : 1;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(size - 1);

  logic [2:0]                 state_reg, state_next;
  logic [cnt_w-1:0]           cnt_reg;
  logic [3:0]                 op_reg;
  logic [act_type_size-1:0]   act_type_reg;
  logic [dense_type_size-1:0] dense_type_reg;
  logic [cost_type_size-1:0]  cost_type_reg;
  logic [31:0]                w_layer_index_reg, w_row_index_reg;
  logic                       is_update_reg, load_w_reg, backprop_cost_reg;
  logic                       out_valid_reg, illegal_op_reg;

  logic                 accept;
  logic                 last_elem;
  logic                 loading;
  logic                 hdr_legal;
  logic                 hdr_illegal;
  logic [3:0]           hdr_op;
  logic [data_size-1:0] elem;

  assign bus.in_ready = (state_reg != EMIT);
  assign accept       = bus.in_valid && bus.in_ready;
  assign last_elem    = (cnt_reg == cnt_last);
  assign loading      = (state_reg == LD_W) || (state_reg == LD_X) || (state_reg == LD_LBL);
  assign hdr_op       = bus.in_word[3:0];
  assign hdr_legal    = (hdr_op == OP_LOAD_W) || (hdr_op == OP_FORWARD) ||
                        (hdr_op == OP_TRAIN)  || (hdr_op == OP_BACKPROP);
  assign hdr_illegal  = (state_reg == IDLE) && accept && !hdr_legal;
  assign elem         = bus.in_word[data_size-1:0];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          case (hdr_op)
            OP_LOAD_W:             state_next = IDX_L;
            OP_FORWARD, OP_TRAIN:  state_next = LD_X;
            OP_BACKPROP:           state_next = LD_LBL;
            default:               state_next = IDLE;
          endcase
        end
      end
      IDX_L:  if (accept) state_next = IDX_R;
      IDX_R:  if (accept) state_next = LD_W;
      LD_W:   if (accept && last_elem) state_next = EMIT;
      // TRAIN carries a label vector after its input vector
      LD_X:   if (accept && last_elem) state_next = (op_reg == OP_TRAIN) ? LD_LBL : EMIT;
      LD_LBL: if (accept && last_elem) state_next = EMIT;
      EMIT:   if (out_valid_reg && bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      cnt_reg           <= '0;
      op_reg            <= '0;
      act_type_reg      <= '0;
      dense_type_reg    <= '0;
      cost_type_reg     <= '0;
      w_layer_index_reg <= '0;
      w_row_index_reg   <= '0;
      is_update_reg     <= 1'b0;
      load_w_reg        <= 1'b0;
      backprop_cost_reg <= 1'b0;
      out_valid_reg     <= 1'b0;
      illegal_op_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      out_valid_reg  <= (state_next == EMIT);
      illegal_op_reg <= hdr_illegal;

      if (state_next != state_reg)
        cnt_reg <= '0;
      else if (accept && loading)
        cnt_reg <= cnt_reg + 1'b1;

      // Types and flags are taken from every legal header; vectors are not
      if ((state_reg == IDLE) && accept && hdr_legal) begin
        op_reg            <= hdr_op;
        act_type_reg      <= bus.in_word[4 +: act_type_size];
        dense_type_reg    <= bus.in_word[8 +: dense_type_size];
        cost_type_reg     <= bus.in_word[12 +: cost_type_size];
        load_w_reg        <= (hdr_op == OP_LOAD_W);
        is_update_reg     <= (hdr_op == OP_TRAIN);
        backprop_cost_reg <= (hdr_op == OP_BACKPROP);
      end

      if ((state_reg == IDX_L) && accept) w_layer_index_reg <= bus.in_word;
      if ((state_reg == IDX_R) && accept) w_row_index_reg   <= bus.in_word;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < size; gi++) begin : g_elem
      localparam logic [cnt_w-1:0] elem_idx = cnt_w'(gi);
      logic [data_size-1:0] w_elem_reg, x_elem_reg, label_elem_reg;
      logic                 hit;

      assign hit = accept && (cnt_reg == elem_idx);

      always_ff @(posedge clk) begin
        if (rst) begin
          w_elem_reg     <= '0;
          x_elem_reg     <= '0;
          label_elem_reg <= '0;
        end else begin
          if (hit && (state_reg == LD_W))   w_elem_reg     <= elem;
          if (hit && (state_reg == LD_X))   x_elem_reg     <= elem;
          if (hit && (state_reg == LD_LBL)) label_elem_reg <= elem;
        end
      end

      assign bus.w[gi*data_size +: data_size]     = w_elem_reg;
      assign bus.x[gi*data_size +: data_size]     = x_elem_reg;
      assign bus.label[gi*data_size +: data_size] = label_elem_reg;
    end
  endgenerate

`ifdef DECODE_ERR_COUNT_EN
  logic [15:0] err_count_reg;

  always_ff @(posedge clk) begin
    if (rst)
      err_count_reg <= '0;
    else if (hdr_illegal && (err_count_reg != 16'hFFFF))
      err_count_reg <= err_count_reg + 16'd1;
  end

  assign bus.err_count = err_count_reg;
`else
  assign bus.err_count = 16'd0;
`endif

  assign bus.act_type      = act_type_reg;
  assign bus.dense_type    = dense_type_reg;
  assign bus.cost_type     = cost_type_reg;
  assign bus.w_layer_index = w_layer_index_reg;
  assign bus.w_row_index   = w_row_index_reg;
  assign bus.is_update     = is_update_reg;
  assign bus.load_w        = load_w_reg;
  assign bus.backprop_cost = backprop_cost_reg;
  assign bus.out_valid     = out_valid_reg;
  assign bus.illegal_op    = illegal_op_reg;
endmodule

// File: tb/tb_dense_instr_decoder.sv
// Scoreboard bench for dense_instr_decoder: directed cases, random commands, err_count saturation.
`timescale 1ns/1ps
module tb_dense_instr_decoder;
  localparam int SIZE = 3;
  localparam int DS   = 16;

  typedef struct packed {
    logic [3:0]         act;
    logic [3:0]         dense;
    logic [7:0]         cost;
    logic [31:0]        lidx;
    logic [31:0]        ridx;
    logic               is_update;
    logic               load_w;
    logic               backprop;
    logic [SIZE*DS-1:0] w;
    logic [SIZE*DS-1:0] x;
    logic [SIZE*DS-1:0] label;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dense_instr_decoder_if #(.size(SIZE), .data_size(DS), .cost_type_size(8),
                           .dense_type_size(4), .act_type_size(4)) dif ();

  dense_instr_decoder #(.size(SIZE), .data_size(DS), .cost_type_size(8),
                        .dense_type_size(4), .act_type_size(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(dif)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          total = 0;
  int          bad = 0;
  cmd_t        exp_q[$];
  cmd_t        model;
  logic [31:0] pay_q[$];
  int          hs_log[$];
  int          hdr_cyc = 0;
  int          rise_cyc = 0;
  int          n_done = 0;
  int          n_ill = 0;
  int          n_ill_seen = 0;
  int          err_model = 0;
  int          rdy_mode = 0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic int exp_err();
`ifdef DECODE_ERR_COUNT_EN
    return (err_model > 65535) ? 65535 : err_model;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    model     = '0;
    err_model = 0;
  endtask

  task automatic check_reset(input string name);
    check(name, {dif.out_valid, dif.illegal_op, dif.err_count, dif.act_type, dif.dense_type,
                 dif.cost_type, dif.w, dif.x, dif.label, dif.w_layer_index, dif.w_row_index,
                 dif.is_update, dif.load_w, dif.backprop_cost}, '0);
    check({name, "_in_ready"}, dif.in_ready, 1'b1);
  endtask

  // Monitor: compares the held command against the scoreboard head every cycle
  initial begin
    logic prev_valid;
    cmd_t got;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        if (dif.illegal_op) n_ill_seen++;
        if (dif.out_valid) begin
          if (!prev_valid) rise_cyc = cyc;
          check("in_ready_in_emit", dif.in_ready, 1'b0);
          check("cmd_pending", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            got = {dif.act_type, dif.dense_type, dif.cost_type, dif.w_layer_index,
                   dif.w_row_index, dif.is_update, dif.load_w, dif.backprop_cost,
                   dif.w, dif.x, dif.label};
            check("cmd_fields", got, exp_q[0]);
            if (dif.out_ready) begin
              void'(exp_q.pop_front());
              hs_log.push_back(cyc);
              n_done++;
              $display("cmd %0d taken at cycle %0d act=%0h dense=%0h cost=%0h flags=%b%b%b",
                       n_done, cyc, got.act, got.dense, got.cost,
                       got.load_w, got.is_update, got.backprop);
            end
          end
        end
        prev_valid = dif.out_valid;
      end
    end
  end

  initial begin
    dif.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       dif.out_ready = 1'b1;
        1:       dif.out_ready = 1'b0;
        default: dif.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic send_word(input logic [31:0] word, output int acc_cyc);
    int t;
    t = 0;
    dif.in_word  = word;
    dif.in_valid = 1'b1;
    acc_cyc = -1;
    forever begin
      @(negedge clk);
      if (dif.in_ready && !rst) break;
      t++;
      if (t > 500) break;
    end
    if (t > 500) begin
      check("in_ready_timeout", 1'b0, 1'b1);
    end else begin
      acc_cyc = cyc;
      @(posedge clk);
    end
    #1;
    dif.in_valid = 1'b0;
  endtask

  task automatic gap(input bit en);
    if (en) repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: applies the opcode rules to pay_q, queues the expected command, then drives it
  task automatic issue_cmd(input logic [31:0] hdr, input bit gaps);
    logic [31:0] p[$];
    logic [3:0]  op;
    int          k, c;
    p = pay_q;
    pay_q.delete();
    op = hdr[3:0];
    if (op < 1 || op > 4) begin
      n_ill++;
      err_model++;
      send_word(hdr, c);
      return;
    end
    model.act       = hdr[7:4];
    model.dense     = hdr[11:8];
    model.cost      = hdr[19:12];
    model.load_w    = (op == 1);
    model.is_update = (op == 3);
    model.backprop  = (op == 4);
    k = 0;
    if (op == 1) begin
      model.lidx = p[0];
      model.ridx = p[1];
      for (int i = 0; i < SIZE; i++) model.w[i*DS +: DS] = p[2+i][DS-1:0];
    end
    if (op == 2 || op == 3) begin
      for (int i = 0; i < SIZE; i++) model.x[i*DS +: DS] = p[i][DS-1:0];
      k = SIZE;
    end
    if (op == 3 || op == 4) begin
      for (int i = 0; i < SIZE; i++) model.label[i*DS +: DS] = p[k+i][DS-1:0];
    end
    exp_q.push_back(model);
    send_word(hdr, hdr_cyc);
    foreach (p[i]) begin
      gap(gaps);
      send_word(p[i], c);
    end
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) pay_q.push_back($urandom);
  endtask

  task automatic wait_empty();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    int   idx, done0, t, c, op, v;
    logic [31:0] hdr;

    dif.in_valid = 1'b0;
    dif.in_word  = '0;
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset("reset_state");

    // FORWARD 1,2,3 with continuous valid: latency and packing
    @(posedge clk); #1;
    rdy_mode = 0;
    pay_q = '{32'h1, 32'h2, 32'h3};
    issue_cmd(32'h0000_0002, 1'b0);
    wait_empty();
    check("fwd_latency", rise_cyc - hdr_cyc, 1 + SIZE);
    check("fwd_x", dif.x, 48'h0003_0002_0001);
    check("fwd_flags", {dif.load_w, dif.is_update, dif.backprop_cost}, 3'b000);

    pay_q = '{32'd7, 32'd2, 32'hA, 32'hB, 32'hC};
    issue_cmd(32'h0002_3451, 1'b0);
    wait_empty();
    check("ldw_types", {dif.act_type, dif.dense_type, dif.cost_type}, 16'h5423);
    check("ldw_idx", {dif.w_layer_index, dif.w_row_index}, {32'd7, 32'd2});
    check("ldw_w", dif.w, 48'h000C_000B_000A);
    check("ldw_flag", dif.load_w, 1'b1);

    pay_q = '{32'h1, 32'h2, 32'h3, 32'h1000_0004, 32'h1000_0005, 32'h1000_0006};
    issue_cmd(32'h0000_0003, 1'b1);
    wait_empty();
    check("train_label", dif.label, 48'h0006_0005_0004);
    check("train_flag", {dif.is_update, dif.load_w}, 2'b10);
    check("train_w_kept", dif.w, 48'h000C_000B_000A);

    issue_cmd(32'h0000_000F, 1'b0);
    repeat (3) @(negedge clk);
    check("illegal_pulses", n_ill_seen, n_ill);
    check("illegal_err_count", dif.err_count, exp_err());
    check("illegal_no_valid", dif.out_valid, 1'b0);

    // Stall in EMIT with the next header already waiting
    @(posedge clk); #1;
    rdy_mode = 1;
    fill_rand(SIZE);
    issue_cmd({$urandom, 4'h2} >> 4 << 4 | 32'h2, 1'b0);
    idx = hs_log.size();
    fill_rand(2 * SIZE);
    fork
      issue_cmd(($urandom & 32'hFFFF_FFF0) | 32'h3, 1'b0);
    join_none
    repeat (10) @(posedge clk);
    #1;
    rdy_mode = 0;
    wait fork;
    wait_empty();
    if (hs_log.size() > idx) check("stall_hdr_accept", hdr_cyc, hs_log[idx] + 1);
    else check("stall_handshake_seen", hs_log.size(), idx + 1);

    // Reset while a command is held in EMIT
    rdy_mode = 1;
    fill_rand(SIZE);
    issue_cmd(($urandom & 32'hFFFF_FFF0) | 32'h4, 1'b0);
    t = 0;
    while (!dif.out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("emit_reached", dif.out_valid, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    check_reset("reset_in_emit");

    // Reset after two of three x words, then a full FORWARD
    @(posedge clk); #1;
    send_word(32'h0000_0552, c);
    send_word(32'h0000_1111, c);
    send_word(32'h0000_2222, c);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset("reset_partial");
    @(posedge clk); #1;
    done0 = n_done;
    pay_q = '{32'h0000_0009, 32'h0000_0008, 32'h0000_0007};
    issue_cmd(32'h0000_0002, 1'b1);
    wait_empty();
    check("after_reset_count", n_done, done0 + 1);
    check("after_reset_x", dif.x, 48'h0007_0008_0009);

    // Random command mix under random backpressure and input gaps
    rdy_mode = 2;
    for (int n = 0; n < 150; n++) begin
      v = $urandom_range(0, 9);
      if (v < 8) op = (v % 4) + 1;
      else begin
        op = $urandom_range(5, 16);
        if (op == 16) op = 0;
      end
      hdr = ($urandom & 32'hFFFF_FFF0) | 32'(op);
      case (op)
        1:       fill_rand(2 + SIZE);
        2, 4:    fill_rand(SIZE);
        3:       fill_rand(2 * SIZE);
        default: ;
      endcase
      issue_cmd(hdr, 1'b1);
    end
    wait_empty();
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    check("rand_illegal_pulses", n_ill_seen, n_ill);
    check("rand_err_count", dif.err_count, exp_err());

    // Saturation: enough back-to-back illegal headers to pass 0xFFFF
    @(posedge clk); #1;
    for (int n = 0; n < 32'h10005; n++)
      issue_cmd(($urandom & 32'hFFFF_FFF0) | 32'hF, 1'b0);
    repeat (3) @(negedge clk);
    check("sat_err_count", dif.err_count, exp_err());
    check("sat_illegal_pulses", n_ill_seen, n_ill);
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dense_instr_decoder.md
# dense_instr_decoder

Instruction decoder feeding the dense-layer decode register. It accepts a stream of 32-bit instruction words over a valid/ready handshake, parses a header word and its payload words, and assembles one complete dense command. The command carries the activation, dense and cost types, weight row, layer and row indices, control flags, input vector and label vector. It presents the command on a held valid/ready output whose fields connect one-to-one to the inputs of the decode register stage.

## Interface
- `size`, 3: number of vector elements in w / x / label
- `data_size`, 16: bits per element; legal range 1..32
- `cost_type_size`, 8; `dense_type_size`, 4; `act_type_size`, 4: field widths
- `clk`  in  1  clock; all logic on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_word`  in  32  instruction word
- `in_valid`  in  1  in_word valid
- `in_ready`  out  1  decoder accepts in_word this cycle
- `act_type`, `dense_type`, `cost_type`  out  4 / 4 / 8  types from the header
- `w`, `x`, `label`  out  data_size*size each  assembled vectors; element i occupies `[i*data_size +: data_size]`
- `w_layer_index`, `w_row_index`  out  32 each  weight target indices
- `is_update`, `load_w`, `backprop_cost`  out  1 each  command flags
- `out_valid`  out  1  command complete and held
- `out_ready`  in  1  downstream consumes the command
- `illegal_op`  out  1  one-cycle pulse on an unknown opcode
- `err_count`  out  16  illegal-opcode count (see Configuration)

## Operation
- Header word layout: `[3:0]` opcode, `[7:4]` act_type, `[11:8]` dense_type, `[19:12]` cost_type, `[31:20]` ignored.
- Opcode 1, LOAD_W: payload is layer index, row index, then `size` w words. Sets load_w=1.
- Opcode 2, FORWARD: payload is `size` x words. All flags are 0.
- Opcode 3, TRAIN: payload is `size` x words, then `size` label words. Sets is_update=1.
- Opcode 4, BACKPROP: payload is `size` label words. Sets backprop_cost=1.
- Any other opcode: the header is dropped. `illegal_op` pulses for one cycle and the decoder stays in IDLE.
- Data words: the element is the low `data_size` bits of in_word. Upper bits are discarded. Elements fill from index 0 upward.
- Vector fields the opcode does not carry keep their previous values. Type fields and flags always update from the new header.
- States: IDLE, IDX_L, IDX_R, LD_W, LD_X, LD_LBL, EMIT.
  - IDLE, on a legal header: go to IDX_L for op 1, LD_X for ops 2/3, LD_LBL for op 4.
  - IDX_L -> IDX_R -> LD_W.
  - LD_W or LD_X, after `size` words: go to EMIT; op 3 goes from LD_X to LD_LBL instead.
  - LD_LBL, after `size` words: go to EMIT.
  - EMIT, on `out_valid && out_ready`: go to IDLE.
- The element counter is 0..size-1 and resets to 0 on every state change.
- `in_ready` = 1 in every state except EMIT.
- Reset: all outputs 0, state IDLE, counter 0, err_count 0. Reset in the middle of a command discards the partial command. Reset while in EMIT drops out_valid the next cycle.

## Timing
- A word transfers when `in_valid && in_ready` at the clock edge.
- out_valid rises on the cycle after the last payload word is accepted. Minimum latency from header to out_valid is 1+size cycles for FORWARD.
- All output fields are registered. They are stable while out_valid=1 and change only after the handshake.
- After the output handshake, the decoder spends one cycle in IDLE. A header presented in that cycle is accepted. Peak throughput is one command per payload+2 cycles.
- in_valid gaps stall the FSM without side effects.
- illegal_op asserts on the cycle after the bad header is accepted.

## Configuration
- `DECODE_ERR_COUNT_EN` defined: err_count increments on each illegal opcode and saturates at 0xFFFF. It clears only on rst.
- Not defined: the counter logic is not built and err_count is tied to 0. The illegal_op pulse is present in both builds.

## Test plan
- Reset, then FORWARD with size=3 and words 0x1, 0x2, 0x3 -> out_valid after the 4th accepted word; x=0x0003_0002_0001; flags 0; in_ready=0 until out_ready.
- LOAD_W header 0x0002_3451 with indices 7, 2 and w words 0xA, 0xB, 0xC -> act_type=5, dense_type=4, cost_type=0x23, w_layer_index=7, w_row_index=2, w=0x000C_000B_000A, load_w=1.
- TRAIN with x 1..3 and label 0x10000004..0x10000006 -> upper bits truncated, label=0x0006_0005_0004, is_update=1.
- Header opcode 0xF -> one illegal_op pulse, no out_valid; err_count=1 with macro, 0 without. Repeat 0x10005 times -> err_count=0xFFFF.
- rst asserted after 2 of 3 x words, then a full FORWARD -> only the second command is emitted, with the correct x.
- out_ready held low for 10 cycles in EMIT while in_valid=1 -> fields stable, no word accepted; the pending header is accepted 1 cycle after the handshake.
